dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter STARVE_LIM, default 4: consecutive accepted loads after which one IDLE cycle is reserved for a store.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_ld_req  in  1  LSU load request.
REQ-006 i_ld_addr  in  32  load word address.
REQ-007 o_ld_rdy  out  1  load accepted when i_ld_req && o_ld_rdy.
REQ-008 o_ld_done  out  1  one-cycle load completion pulse.
REQ-009 o_ld_data  out  32  load result, valid with o_ld_done.
REQ-010 o_stbuf_ld_addr  out  32  combinational copy of i_ld_addr, for the store-buffer search.
REQ-011 i_stbuf_addr_hit  in  1  store-buffer hit for o_stbuf_ld_addr, same cycle.
REQ-012 i_stbuf_rd_data  in  32  store-buffer forward data, same cycle.
REQ-013 i_ret_stbuf  in  1  store-buffer retire; that entry is popped this cycle.
REQ-014 i_ret_stbuf_addr  in  32  retiring store address.
REQ-015 i_ret_stbuf_data  in  32  retiring store data.
REQ-016 o_dmem_occupy  out  1  retire inhibit to the store buffer; combinational.
REQ-017 o_mem_req  out  1  memory request; held until granted.
REQ-018 o_mem_we  out  1  1 = write, 0 = read.
REQ-019 o_mem_addr  out  32  memory address.
REQ-020 o_mem_wdata  out  32  memory write data.
REQ-021 i_mem_gnt  in  1  memory accepts the request this cycle when o_mem_req is high.
REQ-022 i_mem_rvalid  in  1  read data valid; earliest one cycle after the read grant.
REQ-023 i_mem_rdata  in  32  read data.

Function
REQ-024 FSM states SHALL be: IDLE, ST_REQ, LD_REQ, LD_WAIT.
REQ-025 o_ld_rdy SHALL equal (state==IDLE) && !(starve_cnt==STARVE_LIM).
REQ-026 o_dmem_occupy SHALL equal !(state==IDLE) || (i_ld_req && o_ld_rdy).
- Priority: load over store.
- A store is retired only when o_dmem_occupy is low.
REQ-027 IDLE with i_ret_stbuf:
- Capture address/data into the write register.
- Go to ST_REQ.
- Reset starve_cnt to 0.
REQ-028 ST_REQ:
- o_mem_req=1, o_mem_we=1, addr/wdata from the write register.
- On i_mem_gnt go to IDLE.
REQ-029 Load accepted with i_stbuf_addr_hit=1:
- State stays IDLE.
- Next cycle o_ld_done=1 and o_ld_data=captured i_stbuf_rd_data.
- No memory access.
REQ-030 Load accepted with hit=0:
- Capture the address; go to LD_REQ.
- LD_REQ: o_mem_req=1, o_mem_we=0; on i_mem_gnt go to LD_WAIT.
REQ-031 LD_WAIT: on i_mem_rvalid, o_ld_done=1 with o_ld_data=i_mem_rdata on the next cycle; state goes to IDLE.
REQ-032 i_mem_rvalid in any state other than LD_WAIT SHALL be ignored.
REQ-033 starve_cnt (saturating at STARVE_LIM):
- +1 on each accepted load.
- Cleared on a store capture.
- Cleared on any IDLE cycle with neither a load acceptance nor i_ret_stbuf.
REQ-034 When starve_cnt==STARVE_LIM, o_ld_rdy SHALL be low in IDLE; the count SHALL clear after that IDLE cycle.
REQ-035 Outside ST_REQ/LD_REQ: o_mem_req=0, o_mem_we=0, o_mem_addr/o_mem_wdata=0.
REQ-036 o_ld_done SHALL be registered and high for exactly one cycle per accepted load.
REQ-037 At most one memory transaction SHALL be outstanding.
REQ-038 All addresses SHALL be word addresses; only full 32-bit accesses are supported.

Reset
REQ-039 Reset SHALL force:
- state=IDLE, starve_cnt=0.
- Write register and captured load address = 0.
- o_ld_done=0, o_ld_data=0, o_mem_req=0.
REQ-040 o_dmem_occupy SHALL be 1 while rst is high.
REQ-041 A reset mid-transaction SHALL discard the pending store or load; no o_ld_done SHALL follow.

Verification
REQ-042 Store retire: i_ret_stbuf with addr 0x100, data 0xDEAD_BEEF, i_mem_gnt delayed 3 cycles -> o_mem_req/we high 3 cycles at 0x100/0xDEADBEEF; o_dmem_occupy high until the cycle after the grant.
REQ-043 Forward: load 0x200 with i_stbuf_addr_hit=1, data 0x1234 -> o_ld_done next cycle with 0x1234; o_mem_req stays 0.
REQ-044 Miss: load 0x300, grant immediately, rvalid 2 cycles later with 0xCAFE -> o_ld_done one cycle after rvalid with 0xCAFE; o_ld_rdy low throughout.
REQ-045 Contention: i_ld_req and a committed store together in IDLE -> load accepted, occupy high; store retires on the first IDLE cycle without a load.
REQ-046 Starvation: continuous forwarded loads plus a pending store -> after 4 accepts, o_ld_rdy drops for one IDLE cycle and the store is captured.
REQ-047 Reset in LD_WAIT, then rvalid -> state IDLE, no o_ld_done, rvalid ignored.

Source files
------------

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- data-memory controller between the LSU, the store buffer and a
// single-port memory.
//
// Loads are served either by same-cycle forwarding from the store buffer or by
// a read transaction to memory. Stores retire from the store buffer one at a
// time into a write register and are then written to memory. Loads have
// priority over stores. A starvation counter reserves one IDLE cycle for a
// store after STARVE_LIM consecutive load acceptances.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_ld_req/i_ld_addr  LSU load request and word address
//   o_ld_rdy            load accepted when i_ld_req && o_ld_rdy
//   o_ld_done/o_ld_data registered one-cycle completion pulse and result
//   o_stbuf_ld_addr     load address forwarded to the store-buffer search
//   i_stbuf_addr_hit    store-buffer hit for o_stbuf_ld_addr (same cycle)
//   i_stbuf_rd_data     store-buffer forward data (same cycle)
//   i_ret_stbuf*        store-buffer retire strobe, address and data
//   o_dmem_occupy       retire inhibit to the store buffer (combinational)
//   o_mem_*             memory request channel (held until i_mem_gnt)
//   i_mem_gnt           memory grant
//   i_mem_rvalid/rdata  memory read response
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ld_req,
  input  logic [31:0] i_ld_addr,
  output logic        o_ld_rdy,
  output logic        o_ld_done,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_stbuf_ld_addr,
  input  logic        i_stbuf_addr_hit,
  input  logic [31:0] i_stbuf_rd_data,
  input  logic        i_ret_stbuf,
  input  logic [31:0] i_ret_stbuf_addr,
  input  logic [31:0] i_ret_stbuf_data,
  output logic        o_dmem_occupy,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_starve_cnt;
  logic [31:0]   r_wr_addr;
  logic [31:0]   r_wr_data;
  logic [31:0]   r_ld_addr;
  logic          r_ld_done;
  logic [31:0]   r_ld_data;

  logic w_idle;
  logic w_starved;
  logic w_ld_acc;
  logic w_st_acc;
  logic w_occupy;

  assign w_idle    = (r_state == IDLE);
  assign w_starved = (r_starve_cnt == CW'(STARVE_LIM));
  assign o_ld_rdy  = w_idle && !w_starved;
  assign w_ld_acc  = i_ld_req && o_ld_rdy;
  // rst is folded in so the store buffer never retires into a controller
  // that is being reset.
  assign w_occupy  = rst || !w_idle || w_ld_acc;
  // A retire is only honoured while occupy is low, which also gives loads
  // priority over stores in IDLE.
  assign w_st_acc  = w_idle && i_ret_stbuf && !w_occupy;

  assign o_dmem_occupy   = w_occupy;
  assign o_stbuf_ld_addr = i_ld_addr;
  assign o_ld_done       = r_ld_done;
  assign o_ld_data       = r_ld_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ld_acc) begin
          // Forwarded loads complete without leaving IDLE.
          if (!i_stbuf_addr_hit) w_state_next = LD_REQ;
        end else if (w_st_acc) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ:  if (i_mem_gnt)    w_state_next = IDLE;
      LD_REQ:  if (i_mem_gnt)    w_state_next = LD_WAIT;
      LD_WAIT: if (i_mem_rvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Memory channel outputs
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    case (r_state)
      ST_REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = r_wr_addr;
        o_mem_wdata = r_wr_data;
      end
      LD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_ld_addr;
      end
      default: ;
    endcase
  end

  // Datapath registers, completion pulse and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_wr_addr    <= 32'd0;
      r_wr_data    <= 32'd0;
      r_ld_addr    <= 32'd0;
      r_ld_done    <= 1'b0;
      r_ld_data    <= 32'd0;
    end else begin
      r_ld_done <= 1'b0;

      if (w_st_acc) begin
        r_wr_addr <= i_ret_stbuf_addr;
        r_wr_data <= i_ret_stbuf_data;
      end

      if (w_ld_acc) begin
        if (i_stbuf_addr_hit) begin
          r_ld_done <= 1'b1;
          r_ld_data <= i_stbuf_rd_data;
        end else begin
          r_ld_addr <= i_ld_addr;
        end
      end

      // rvalid outside LD_WAIT is a stray response and is dropped.
      if (r_state == LD_WAIT && i_mem_rvalid) begin
        r_ld_done <= 1'b1;
        r_ld_data <= i_mem_rdata;
      end

      // The count only moves in IDLE: it grows with each acceptance and
      // clears on any IDLE cycle without one (store capture, idle, or the
      // reserved starvation cycle). Busy states hold it.
      if (w_idle) begin
        if (w_ld_acc) begin
          if (!w_starved) r_starve_cnt <= r_starve_cnt + CW'(1);
        end else begin
          r_starve_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl -- randomized self-checking bench for dmem_ctrl.
// The reference model tracks the single outstanding memory transaction as a
// record (kind, address, data, granted) plus the consecutive-load count, and
// predicts every output from those each cycle. The bench also plays the store
// buffer (retiring only while the predicted occupy is low) and the memory
// (random grant delay, random read latency, stray rvalid pulses).
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int LIM    = 4;
  localparam int CYCLES = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ld_req;
  logic [31:0] i_ld_addr;
  logic        o_ld_rdy;
  logic        o_ld_done;
  logic [31:0] o_ld_data;
  logic [31:0] o_stbuf_ld_addr;
  logic        i_stbuf_addr_hit;
  logic [31:0] i_stbuf_rd_data;
  logic        i_ret_stbuf;
  logic [31:0] i_ret_stbuf_addr;
  logic [31:0] i_ret_stbuf_data;
  logic        o_dmem_occupy;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.STARVE_LIM(LIM)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_ld_req         (i_ld_req),
    .i_ld_addr        (i_ld_addr),
    .o_ld_rdy         (o_ld_rdy),
    .o_ld_done        (o_ld_done),
    .o_ld_data        (o_ld_data),
    .o_stbuf_ld_addr  (o_stbuf_ld_addr),
    .i_stbuf_addr_hit (i_stbuf_addr_hit),
    .i_stbuf_rd_data  (i_stbuf_rd_data),
    .i_ret_stbuf      (i_ret_stbuf),
    .i_ret_stbuf_addr (i_ret_stbuf_addr),
    .i_ret_stbuf_data (i_ret_stbuf_data),
    .o_dmem_occupy    (o_dmem_occupy),
    .o_mem_req        (o_mem_req),
    .o_mem_we         (o_mem_we),
    .o_mem_addr       (o_mem_addr),
    .o_mem_wdata      (o_mem_wdata),
    .i_mem_gnt        (i_mem_gnt),
    .i_mem_rvalid     (i_mem_rvalid),
    .i_mem_rdata      (i_mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy;      // a memory transaction is outstanding
  bit          m_store;     // outstanding transaction is a write
  bit          m_granted;   // read granted, waiting for data
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          m_cnt;       // consecutive accepted loads
  bit          m_done;
  logic [31:0] m_ld_data;

  // predicted combinational outputs for the current inputs
  bit          e_rdy, e_acc, e_occupy, e_req, e_we;
  logic [31:0] e_addr, e_wdata;

  // bench-side store buffer / memory state
  bit sb_pending;
  int rv_cnt;
  int n_loads, n_stores, n_starve;

  task automatic model_reset();
    m_busy = 0; m_store = 0; m_granted = 0;
    m_addr = '0; m_data = '0;
    m_cnt = 0; m_done = 0; m_ld_data = '0;
  endtask

  task automatic predict();
    e_rdy    = !m_busy && (m_cnt != LIM);
    e_acc    = i_ld_req && e_rdy;
    e_occupy = rst || m_busy || e_acc;
    e_req    = m_busy && !m_granted;
    e_we     = e_req && m_store;
    e_addr   = e_req ? m_addr : 32'd0;
    e_wdata  = e_we ? m_data : 32'd0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (!e_rdy) n_starve++;
        if (e_acc) begin
          m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
          if (i_stbuf_addr_hit) begin
            m_done = 1; m_ld_data = i_stbuf_rd_data;
          end else begin
            m_busy = 1; m_store = 0; m_granted = 0; m_addr = i_ld_addr;
          end
        end else if (i_ret_stbuf) begin
          m_busy = 1; m_store = 1; m_granted = 0;
          m_addr = i_ret_stbuf_addr; m_data = i_ret_stbuf_data;
          m_cnt = 0;
        end else begin
          m_cnt = 0;
        end
      end else if (!m_granted) begin
        if (i_mem_gnt) begin
          if (m_store) begin
            m_busy = 0;
            n_stores++;
            $display("STORE addr=0x%08h data=0x%08h", m_addr, m_data);
          end else begin
            m_granted = 1;
            rv_cnt = $urandom_range(1, 3);
          end
        end
      end else if (i_mem_rvalid) begin
        m_busy = 0; m_done = 1; m_ld_data = i_mem_rdata;
      end else begin
        rv_cnt--;
      end
    end
    if (i_ret_stbuf) sb_pending = 0;
  endtask

  task automatic drive(input int mode);
    rst = ($urandom_range(0, 199) == 0);
    if (mode == 1) begin
      // back-to-back forwarded loads with a store always waiting
      i_ld_req         = ($urandom_range(0, 9) != 0);
      i_stbuf_addr_hit = ($urandom_range(0, 9) != 0);
      sb_pending       = 1;
    end else begin
      i_ld_req         = $urandom_range(0, 1) == 1;
      i_stbuf_addr_hit = $urandom_range(0, 1) == 1;
      if (!sb_pending) sb_pending = ($urandom_range(0, 3) == 0);
    end
    i_ld_addr        = $urandom;
    i_stbuf_rd_data  = $urandom;
    i_ret_stbuf_addr = $urandom;
    i_ret_stbuf_data = $urandom;
    i_mem_gnt        = ($urandom_range(0, 2) != 0);
    i_mem_rdata      = $urandom;
    if (m_busy && !m_store && m_granted) i_mem_rvalid = (rv_cnt == 1);
    else                                 i_mem_rvalid = ($urandom_range(0, 7) == 0);
    predict();
    i_ret_stbuf = sb_pending && !e_occupy;
  endtask

  initial begin
    bit was_rst;
    rst = 1; i_ld_req = 0; i_ld_addr = '0; i_stbuf_addr_hit = 0;
    i_stbuf_rd_data = '0; i_ret_stbuf = 0; i_ret_stbuf_addr = '0;
    i_ret_stbuf_data = '0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    sb_pending = 0; rv_cnt = 0; n_loads = 0; n_stores = 0; n_starve = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ld_done", o_ld_done, 0);
    chk("reset_ld_data", o_ld_data, 0);
    chk("reset_mem_req", o_mem_req, 0);
    chk("reset_occupy",  o_dmem_occupy, 1);
    chk("reset_ld_rdy",  o_ld_rdy, 1);
    rst = 0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      drive((cyc / 250) % 2);
      #1;
      chk("ld_rdy",     o_ld_rdy, e_rdy);
      chk("occupy",     o_dmem_occupy, e_occupy);
      chk("mem_req",    o_mem_req, e_req);
      chk("mem_we",     o_mem_we, e_we);
      chk("mem_addr",   o_mem_addr, e_addr);
      if (!e_req || e_we) chk("mem_wdata", o_mem_wdata, e_wdata);
      chk("stbuf_addr", o_stbuf_ld_addr, i_ld_addr);

      was_rst = rst;
      @(posedge clk);
      #1;
      model_step();
      chk("ld_done", o_ld_done, m_done);
      if (m_done) begin
        chk("ld_data", o_ld_data, m_ld_data);
        n_loads++;
        $display("LOAD  data=0x%08h", m_ld_data);
      end
      if (was_rst) chk("rst_ld_data", o_ld_data, 0);
    end

    $display("INFO loads=%0d stores=%0d starve_cycles=%0d", n_loads, n_stores, n_starve);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
